// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one word load/store at a time,
// fixed access latency, combinational stall and a registered one-cycle completion pulse.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               capture, commit;
    logic               we_p0;
    logic [31:0]        addr_p0;
    logic [31:0]        wdata_p0;
    logic               acc_err;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem [DEPTH];

    function automatic logic access_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    endfunction

    assign acc_err = access_err(addr_p0);
    assign idx     = addr_p0[IDX_W+1:2];

    // Control state: FSM and latency counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    stall_o = 1'b1;
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Pipeline advances on this edge; new requests wait one cycle in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture stage: later changes on the request inputs are ignored
    always_ff @(posedge clk_i) begin
        if (capture) begin
            we_p0    <= we_i;
            addr_p0  <= addr_i;
            wdata_p0 <= wdata_i;
        end
    end

    // Commit stage: array write and registered response
    always_ff @(posedge clk_i) begin
        if (commit && we_p0 && !acc_err) begin
            mem[idx] <= wdata_p0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 32'd0;
        end else if (commit) begin
            ack_o <= 1'b1;
            err_o <= acc_err;
            if (acc_err) begin
                rdata_o <= 32'd0;
            end else if (!we_p0) begin
                rdata_o <= mem[idx];
            end
        end else if (state_q == RESP) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end
    end

endmodule
